// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - board geometry, row/board types and clear-engine states
package board_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int CELL_W     = 4;

  typedef logic [CELL_W-1:0]       cell_t;
  typedef cell_t [BOARD_COLS-1:0]  row_t;
  typedef row_t  [BOARD_ROWS-1:0]  board_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } clr_state_t;

endpackage

// File: rtl/board_clear_engine_row_reg.sv
// rtl/board_clear_engine_row_reg.sv - one board row: snapshot load or shift-down load
module board_row_reg #(
  parameter int COLS = 10,
  parameter int CW   = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     LoadAll,
  input  logic [COLS-1:0][CW-1:0]  AllIn,
  input  logic                     LoadShift,
  input  logic [COLS-1:0][CW-1:0]  ShiftIn,
  output logic [COLS-1:0][CW-1:0]  RowOut
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RowOut <= '0;
    end else if (LoadAll) begin
      RowOut <= AllIn;
    end else if (LoadShift) begin
      RowOut <= ShiftIn;
    end
  end

endmodule

// File: rtl/board_clear_engine.sv
// rtl/board_clear_engine.sv - bottom-up full-row scan and collapse of a board snapshot
// Optional CLEAR_MASK_EN adds ClearedMask (original-board positions of removed rows).
module board_clear_engine
  import board_pkg::*;
#(
  parameter int ROWS = BOARD_ROWS,
  parameter int COLS = BOARD_COLS,
  parameter int CW   = CELL_W
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                Start,
  input  logic [ROWS-1:0][COLS-1:0][CW-1:0]   BoardIn,
  output logic                                Busy,
  output logic                                Done,
  output logic [ROWS-1:0][COLS-1:0][CW-1:0]   BoardOut,
  output logic [$clog2(ROWS+1)-1:0]           LinesCleared
`ifdef CLEAR_MASK_EN
  ,
  output logic [ROWS-1:0]                     ClearedMask
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW = $clog2(ROWS + 1);

  clr_state_t              state, state_nx;
  logic [RW-1:0]           r;
  logic [LW-1:0]           lines;
  logic [COLS-1:0][CW-1:0] cur_row;
  logic                    row_full;
  logic                    load_all;
  logic                    do_shift;

  assign cur_row      = BoardOut[r];
  assign LinesCleared = lines;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (cur_row[c] == '0) row_full = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    load_all = 1'b0;
    do_shift = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load_all = 1'b1;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        Busy = 1'b1;
        if (row_full)      state_nx = SHIFT;
        else if (r == '0)  state_nx = DONE;
      end
      SHIFT: begin
        Busy     = 1'b1;
        do_shift = 1'b1;
        state_nx = SCAN;
      end
      DONE: begin
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // r stays put across a SHIFT so the row dropped into position r is re-checked
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      r     <= '0;
      lines <= '0;
    end else begin
      state <= state_nx;
      if (load_all) begin
        r     <= RW'(ROWS - 1);
        lines <= '0;
      end else begin
        if (state == SCAN && !row_full && r != '0) r <= r - 1'b1;
        if (do_shift) lines <= lines + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_row
    logic [COLS-1:0][CW-1:0] shift_in;
    if (k == 0) begin : g_top
      assign shift_in = '0;
    end else begin : g_below
      assign shift_in = BoardOut[k-1];
    end
    board_row_reg #(
      .COLS (COLS),
      .CW   (CW)
    ) u_row (
      .Clk       (Clk),
      .Reset     (Reset),
      .LoadAll   (load_all),
      .AllIn     (BoardIn[k]),
      .LoadShift (do_shift && (r >= RW'(k))),
      .ShiftIn   (shift_in),
      .RowOut    (BoardOut[k])
    );
  end

`ifdef CLEAR_MASK_EN
  // rows already removed sit below r, so subtracting them gives the original index
  logic [RW-1:0] mask_idx;
  assign mask_idx = r - RW'(lines);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ClearedMask <= '0;
    end else if (load_all) begin
      ClearedMask <= '0;
    end else if (do_shift) begin
      ClearedMask[mask_idx] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_board_clear_engine.sv
// tb/tb_board_clear_engine.sv - scoreboard bench for board_clear_engine
// Honours CLEAR_MASK_EN when the design is built with it.
module tb_board_clear_engine;
  import board_pkg::*;

  localparam int ROWS = BOARD_ROWS;

  typedef struct {
    string      name;
    board_t     board;
    logic [4:0] lines;
    logic [19:0] mask;
    int         done_cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  board_t      BoardIn = '0;
  logic        Busy;
  logic        Done;
  board_t      BoardOut;
  logic [4:0]  LinesCleared;
`ifdef CLEAR_MASK_EN
  logic [19:0] ClearedMask;
`endif

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t sb[$];

  board_t b_t2, b_t3, b_full, e_t2, e_t3;

  board_clear_engine dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .BoardIn      (BoardIn),
    .Busy         (Busy),
    .Done         (Done),
    .BoardOut     (BoardOut),
    .LinesCleared (LinesCleared)
`ifdef CLEAR_MASK_EN
    ,
    .ClearedMask  (ClearedMask)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: every Done pulse is matched against the oldest expectation
  always @(negedge Clk) begin
    if (Reset && Done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got Done=1 expected no pass pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (BoardOut !== e.board) begin
          fails++;
          $display("FAIL %s_board: got %h expected %h", e.name, BoardOut, e.board);
        end
        chk({e.name, "_lines"}, 32'(LinesCleared), 32'(e.lines));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
`ifdef CLEAR_MASK_EN
        chk({e.name, "_mask"}, 32'(ClearedMask), 32'(e.mask));
`endif
      end
    end
  end

  task automatic run_pass(input string nm, input board_t bin, input board_t bexp,
                          input int n, input logic [19:0] mask);
    exp_t e;
    @(negedge Clk);
    BoardIn = bin;
    Start   = 1'b1;
    e.name = nm; e.board = bexp; e.lines = 5'(n); e.mask = mask;
    e.done_cyc = cyc + ROWS + 2 * n + 1;
    sb.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int i;
    for (i = 0; i < 200 && sb.size() != 0; i++) @(negedge Clk);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending passes expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge Clk);
  endtask

  initial begin
    exp_t e1, e2;
    int   k;

    b_t2 = '0; e_t2 = '0;
    for (int c = 0; c < BOARD_COLS; c++) b_t2[19][c] = 4'h3;
    b_t2[18][0] = 4'h5;
    e_t2[19][0] = 4'h5;

    b_t3 = '0; e_t3 = '0;
    for (int c = 0; c < BOARD_COLS; c++) begin
      b_t3[19][c] = 4'h2;
      b_t3[17][c] = 4'h2;
    end
    b_t3[18][0] = 4'h1;
    b_t3[16][0] = 4'h7;
    e_t3[19][0] = 4'h1;
    e_t3[18][0] = 4'h7;

    for (int rr = 0; rr < ROWS; rr++)
      for (int c = 0; c < BOARD_COLS; c++) b_full[rr][c] = 4'hF;

    #1;
    chk("reset_board", 32'(BoardOut != '0), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_lines", 32'(LinesCleared), 32'd0);
`ifdef CLEAR_MASK_EN
    chk("reset_mask", 32'(ClearedMask), 32'd0);
`endif
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    run_pass("empty", '0, '0, 0, 20'h0);
    drain("empty");
    run_pass("one_line", b_t2, e_t2, 1, 20'h80000);
    drain("one_line");
    run_pass("two_lines", b_t3, e_t3, 2, 20'hA0000);
    drain("two_lines");
    run_pass("all_full", b_full, '0, 20, 20'hFFFFF);
    drain("all_full");

    // Asynchronous reset in mid-pass: outputs clear without a clock edge
    @(negedge Clk);
    BoardIn = b_full;
    Start   = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("midreset_board", 32'(BoardOut != '0), 32'd0);
    chk("midreset_busy", 32'(Busy), 32'd0);
    chk("midreset_done", 32'(Done), 32'd0);
    chk("midreset_lines", 32'(LinesCleared), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    run_pass("after_reset", b_t3, e_t3, 2, 20'hA0000);
    drain("after_reset");

    // Start held high: second pass takes the BoardIn present at re-acceptance
    @(negedge Clk);
    BoardIn = '0;
    Start   = 1'b1;
    e1.name = "held_first"; e1.board = '0; e1.lines = 5'd0; e1.mask = 20'h0;
    e1.done_cyc = cyc + ROWS + 1;
    e2.name = "held_second"; e2.board = e_t2; e2.lines = 5'd1; e2.mask = 20'h80000;
    e2.done_cyc = e1.done_cyc + ROWS + 2 + 2;
    sb.push_back(e1);
    sb.push_back(e2);
    repeat (3) @(negedge Clk);
    BoardIn = b_t2;
    for (k = 0; k < 100 && Done !== 1'b1; k++) @(negedge Clk);
    chk("held_first_done_seen", 32'(Done), 32'd1);
    @(negedge Clk);
    chk("held_idle_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    chk("held_rebusy", 32'(Busy), 32'd1);
    Start = 1'b0;
    drain("held");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

endmodule
